adder_nbit: RTL and testbench



---
 rtl/adder_nbit_if.sv | 34 +++
 rtl/adder_nbit.sv | 70 +++++++
 tb/tb_adder_nbit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/adder_nbit_if.sv
// Operand/result bundle for adder_nbit. The overflow signal exists only when
// ADDER_NBIT_OVERFLOW_EN is defined.
interface adder_nbit_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         c_in;
  logic [N-1:0] sum;
  logic         c_out;
  logic         out_valid;
`ifdef ADDER_NBIT_OVERFLOW_EN
  logic         overflow;

  modport master (
    output in_valid, a, b, c_in,
    input  sum, c_out, out_valid, overflow
  );
  modport slave (
    input  in_valid, a, b, c_in,
    output sum, c_out, out_valid, overflow
  );
`else
  modport master (
    output in_valid, a, b, c_in,
    input  sum, c_out, out_valid
  );
  modport slave (
    input  in_valid, a, b, c_in,
    output sum, c_out, out_valid
  );
`endif
endinterface

// File: rtl/adder_nbit.sv
// N-bit ripple-carry adder built from full-adder cells, one register stage.
// Optional signed-overflow output is enabled by defining ADDER_NBIT_OVERFLOW_EN.
module adder_nbit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  adder_nbit_if.slave  bus
);

  logic [N:0]   c;
  logic [N-1:0] s;

  assign c[0] = bus.c_in;

  for (genvar i = 0; i < N; i++) begin : g_fa
    logic p;
    assign p      = bus.a[i] ^ bus.b[i];
    assign s[i]   = p ^ c[i];
    assign c[i+1] = (bus.a[i] & bus.b[i]) | (c[i] & p);
  end

  // Register stage: data holds when in_valid is low, valid strobes for one cycle.
  logic [N-1:0] sum_q,   sum_d;
  logic         c_out_q, c_out_d;
  logic         out_valid_q;

  always_comb begin
    sum_d   = sum_q;
    c_out_d = c_out_q;
    if (bus.in_valid) begin
      sum_d   = s;
      c_out_d = c[N];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      out_valid_q <= bus.in_valid;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.out_valid = out_valid_q;

`ifdef ADDER_NBIT_OVERFLOW_EN
  // Carries into and out of the sign bit disagree exactly on signed overflow.
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q;
    if (bus.in_valid) overflow_d = c[N] ^ c[N-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  assign bus.overflow = overflow_q;
`endif

endmodule

// File: tb/tb_adder_nbit.sv
// Directed/random bench for adder_nbit at N=32 (scoreboarded) and N=8.
module tb_adder_nbit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  adder_nbit_if #(.N(32)) bus ();
  adder_nbit_if #(.N(8))  bus8 ();

  adder_nbit #(.N(32)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  adder_nbit #(.N(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {overflow, c_out, sum}
  logic [33:0] sb_q[$];
  logic [33:0] last_exp;

  function automatic logic [33:0] model32(logic [31:0] a, logic [31:0] b, logic ci);
    logic [32:0] r;
    logic        ov;
    r  = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    ov = (a[31] == b[31]) && (r[31] != a[31]);
    return {ov, r};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(string tag, logic [33:0] exp, logic vld);
    chk({tag, ".sum"}, 64'(bus.sum), 64'(exp[31:0]));
    chk({tag, ".c_out"}, 64'(bus.c_out), 64'(exp[32]));
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(vld));
`ifdef ADDER_NBIT_OVERFLOW_EN
    chk({tag, ".overflow"}, 64'(bus.overflow), 64'(exp[33]));
`endif
  endtask

  task automatic step(string tag, logic [31:0] a, logic [31:0] b, logic ci, logic vld);
    logic [33:0] exp;
    bus.a        = a;
    bus.b        = b;
    bus.c_in     = ci;
    bus.in_valid = vld;
    if (vld) sb_q.push_back(model32(a, b, ci));
    @(posedge clk);
    #1;
    if (vld) begin
      exp      = sb_q.pop_front();
      last_exp = exp;
    end else begin
      exp = last_exp;
    end
    check_outputs(tag, exp, vld);
  endtask

  task automatic step8(string tag, logic [7:0] a, logic [7:0] b, logic ci,
                       logic [7:0] es, logic ec, logic eo);
    bus8.a        = a;
    bus8.b        = b;
    bus8.c_in     = ci;
    bus8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    chk({tag, ".sum"}, 64'(bus8.sum), 64'(es));
    chk({tag, ".c_out"}, 64'(bus8.c_out), 64'(ec));
    chk({tag, ".out_valid"}, 64'(bus8.out_valid), 64'd1);
`ifdef ADDER_NBIT_OVERFLOW_EN
    chk({tag, ".overflow"}, 64'(bus8.overflow), 64'(eo));
`else
    if (eo) begin end
`endif
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    last_exp      = '0;
    bus8.in_valid = 1'b0;
    bus8.a        = '0;
    bus8.b        = '0;
    bus8.c_in     = 1'b0;

    // Reset held with valid operands present: outputs must stay clear.
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.a        = 32'd5;
    bus.b        = 32'd7;
    bus.c_in     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset_hold", 34'd0, 1'b0);

    // Release between edges; nothing valid yet so outputs stay zero.
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b1;
    step("post_reset_idle", 32'd5, 32'd7, 1'b0, 1'b0);

    step("zero", 32'd0, 32'd0, 1'b0, 1'b1);
    step("cin_only", 32'd0, 32'd0, 1'b1, 1'b1);
    step("carry_chain", 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1);
    step("ovf_pos", 32'h7FFF_FFFF, 32'd0, 1'b1, 1'b1);
    step("msb_msb", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
    step("ovf_neg", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);

    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++)
        step("walk1", 32'd1 << i, 32'd1 << j, 1'b0, 1'b1);

    for (int k = 0; k < 128; k++)
      step("random", $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);

    // Hold: outputs frozen while in_valid is low, whatever the operands.
    step("hold_load", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
    chk("hold_load.value", 64'(bus.sum), 64'h2345_6789);
    step("hold_x", 'x, 'x, 1'bx, 1'b0);
    for (int k = 0; k < 4; k++)
      step("hold_rand", $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    chk("hold_final.value", 64'(bus.sum), 64'h2345_6789);

    // Asynchronous reset between edges clears outputs without a clock edge.
    step("pre_async", 32'hDEAD_BEEF, 32'h0101_0101, 1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs("async_reset", 34'd0, 1'b0);

    // In-flight operand during reset is discarded.
    bus.in_valid = 1'b1;
    bus.a        = 32'hFFFF_FFFF;
    bus.b        = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    check_outputs("reset_discard", 34'd0, 1'b0);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b1;
    last_exp = '0;
    sb_q.delete();
    step("after_reset_idle", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    step("after_reset_add", 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b1);
    step("after_reset_drop", 32'd0, 32'd0, 1'b0, 1'b0);

    // Narrow instance.
    step8("n8_wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    step8("n8_msb",  8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    step8("n8_pos",  8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
    step8("n8_mid",  8'h35, 8'h4A, 1'b1, 8'h80, 1'b0, 1'b1);
    step8("n8_zero", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
